// File: rtl/goruntu_ayna_yanit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : goruntu_ayna_yanit_pkg
// Brief    : State codes, default frame geometry and address-width helper
// Revision : 1.0 - initial release
// ============================================================================
package goruntu_ayna_yanit_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    localparam int W_DEF = 320;
    localparam int H_DEF = 240;
    localparam int N_DEF = W_DEF * H_DEF;
    localparam int A_DEF = clog2(N_DEF);

    typedef enum logic [2:0] {
        BOS   = 3'd0,
        AL    = 3'd1,
        OKU   = 3'd2,
        BEKLE = 3'd3,
        SUN   = 3'd4,
        BITTI = 3'd5
    } durum_t;

endpackage
`default_nettype wire

// File: rtl/goruntu_ayna_yanit_if.sv
`default_nettype none
// ============================================================================
// Module   : goruntu_ayna_yanit_if
// Brief    : Pixel-stream handshake between requester (master) and responder
// Revision : 1.0 - initial release
// ============================================================================
interface goruntu_ayna_yanit_if;
    logic [7:0] veri_i;
    logic       veri_gecerli_i;
    logic       veri_al_o;
    logic [7:0] veri_o;
    logic       veri_gonder_o;
    logic       alici_hazir_i;
    logic       islem_bitti_o;

    modport master (
        output veri_i, veri_gecerli_i, alici_hazir_i,
        input  veri_al_o, veri_o, veri_gonder_o, islem_bitti_o
    );

    modport slave (
        input  veri_i, veri_gecerli_i, alici_hazir_i,
        output veri_al_o, veri_o, veri_gonder_o, islem_bitti_o
    );
endinterface
`default_nettype wire

// File: rtl/ram.sv
`default_nettype none
// ============================================================================
// Module   : ram
// Brief    : Single-port RAM, synchronous read with one cycle of latency
// Revision : 1.0 - initial release
// ============================================================================
module ram #(
    parameter int V = 8,
    parameter int S = 76800,
    parameter int A = 17
) (
    input  wire logic         clk_i,
    input  wire logic         we_i,
    input  wire logic [A-1:0] adr_i,
    input  wire logic [V-1:0] veri_i,
    output logic      [V-1:0] veri_o
);
    logic [V-1:0] mem [S];

    always_ff @(posedge clk_i) begin
        if (we_i) mem[adr_i] <= veri_i;
        veri_o <= mem[adr_i];
    end
endmodule
`default_nettype wire

// File: rtl/goruntu_ayna_yanit.sv
`default_nettype none
// ============================================================================
// Module   : goruntu_ayna_yanit
// Brief    : Stores one frame, then streams it back with every row mirrored
// Revision : 1.0 - initial release
// ============================================================================
module goruntu_ayna_yanit
    import goruntu_ayna_yanit_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int H = H_DEF,
    parameter int N = W * H,
    parameter int A = clog2(N)
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    input  wire logic          en_i,
    goruntu_ayna_yanit_if.slave bus,
    output logic      [2:0]    durum_oku_o,
    output logic      [A-1:0]  indis_kontrol
);
    localparam int SW = clog2(W);
    localparam int SH = clog2(H);

    durum_t         durum_q, durum_d;
    logic [A-1:0]   indis_q, indis_d;
    logic [A-1:0]   taban_q, taban_d;
    logic [SH-1:0]  satir_q, satir_d;
    logic [SW-1:0]  sutun_q, sutun_d;
    logic [7:0]     veri_q, veri_d;
    logic           veri_al_q, gonder_q, bitti_q;

    logic           ram_we;
    logic [A-1:0]   ram_adr;
    logic [7:0]     ram_veri;
    logic           kabul;

    assign kabul = bus.veri_gecerli_i & veri_al_q;

    always_comb begin
        durum_d = durum_q;
        indis_d = indis_q;
        taban_d = taban_q;
        satir_d = satir_q;
        sutun_d = sutun_q;
        veri_d  = veri_q;
        ram_we  = 1'b0;
        ram_adr = indis_q;
        unique case (durum_q)
            BOS: begin
                if (en_i) begin
                    indis_d = '0;
                    taban_d = '0;
                    satir_d = '0;
                    sutun_d = '0;
                    durum_d = AL;
                end
            end
            AL: begin
                ram_we = kabul;
                if (kabul) begin
                    if (indis_q == A'(N - 1)) begin
                        indis_d = '0;
                        durum_d = OKU;
                    end else begin
                        indis_d = indis_q + A'(1);
                    end
                end
            end
            OKU: begin
                // Row base plus mirrored column; no multiplier needed.
                ram_adr = taban_q + (A'(W - 1) - A'(sutun_q));
                durum_d = BEKLE;
            end
            BEKLE: begin
                veri_d  = ram_veri;
                durum_d = SUN;
            end
            SUN: begin
                if (bus.alici_hazir_i) begin
                    // Counters freeze on the last pixel so none passes N-1.
                    if (indis_q == A'(N - 1)) begin
                        durum_d = BITTI;
                    end else begin
                        indis_d = indis_q + A'(1);
                        durum_d = OKU;
                        if (sutun_q == SW'(W - 1)) begin
                            sutun_d = '0;
                            satir_d = satir_q + SH'(1);
                            taban_d = taban_q + A'(W);
                        end else begin
                            sutun_d = sutun_q + SW'(1);
                        end
                    end
                end
            end
            BITTI: begin
                if (!en_i) durum_d = BOS;
            end
            default: durum_d = BOS;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            durum_q   <= BOS;
            indis_q   <= '0;
            taban_q   <= '0;
            satir_q   <= '0;
            sutun_q   <= '0;
            veri_q    <= '0;
            veri_al_q <= 1'b0;
            gonder_q  <= 1'b0;
            bitti_q   <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            indis_q   <= indis_d;
            taban_q   <= taban_d;
            satir_q   <= satir_d;
            sutun_q   <= sutun_d;
            veri_q    <= veri_d;
            veri_al_q <= (durum_d == AL);
            gonder_q  <= (durum_d == SUN);
            bitti_q   <= (durum_d == BITTI);
        end
    end

    ram #(
        .V (8),
        .S (N),
        .A (A)
    ) u_ram (
        .clk_i  (clk_i),
        .we_i   (ram_we),
        .adr_i  (ram_adr),
        .veri_i (bus.veri_i),
        .veri_o (ram_veri)
    );

    assign bus.veri_al_o     = veri_al_q;
    assign bus.veri_o        = veri_q;
    assign bus.veri_gonder_o = gonder_q;
    assign bus.islem_bitti_o = bitti_q;
    assign durum_oku_o       = durum_q;
    assign indis_kontrol     = indis_q;
endmodule
`default_nettype wire

// File: tb/tb_goruntu_ayna_yanit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_goruntu_ayna_yanit
// Brief    : Directed bench for a 4x2 frame mirror responder
// Revision : 1.0 - initial release
// ============================================================================
module tb_goruntu_ayna_yanit;
    localparam int W = 4;
    localparam int H = 2;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       en_i;
    logic [2:0] durum;
    logic [2:0] indis;

    goruntu_ayna_yanit_if bus_if();

    goruntu_ayna_yanit #(.W(W), .H(H)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .bus           (bus_if),
        .durum_oku_o   (durum),
        .indis_kontrol (indis)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [8];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic start();
        en_i = 1'b1;
        tick();
        check("start_veri_al", 32'(bus_if.veri_al_o), 1);
        check("start_durum", 32'(durum), 1);
    endtask

    task automatic load(input logic [7:0] base, input int cnt, input bit stall);
        for (int i = 0; i < cnt; i++) begin
            if (stall && $urandom_range(0, 1) == 1) begin
                bus_if.veri_gecerli_i = 1'b0;
                bus_if.veri_i         = 8'hEE;
                tick();
            end
            bus_if.veri_i         = base + tbl[i].pix;
            bus_if.veri_gecerli_i = 1'b1;
            tick();
        end
        bus_if.veri_gecerli_i = 1'b0;
        bus_if.veri_i         = 8'h55;
    endtask

    task automatic collect(input logic [7:0] base, input bit stall);
        int w;
        check("after_load_durum", 32'(durum), 2);
        check("after_load_veri_al", 32'(bus_if.veri_al_o), 0);
        for (int k = 0; k < 8; k++) begin
            w = 0;
            while (bus_if.veri_gonder_o !== 1'b1 && w < 12) begin
                tick();
                w++;
            end
            check("gap", 32'(w), 2);
            check("veri_o", 32'(bus_if.veri_o), 32'(base) + 32'(tbl[k].exp));
            if (stall && k == 2) begin
                bus_if.alici_hazir_i = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check("stall_veri_o", 32'(bus_if.veri_o), 1);
                    check("stall_gonder", 32'(bus_if.veri_gonder_o), 1);
                end
                bus_if.alici_hazir_i = 1'b1;
            end
            tick();
        end
        check("end_bitti", 32'(bus_if.islem_bitti_o), 1);
        check("end_gonder", 32'(bus_if.veri_gonder_o), 0);
        check("end_durum", 32'(durum), 5);
        check("end_indis", 32'(indis), 7);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'd0, 8'd3};
        tbl[1] = '{8'd1, 8'd2};
        tbl[2] = '{8'd2, 8'd1};
        tbl[3] = '{8'd3, 8'd0};
        tbl[4] = '{8'd4, 8'd7};
        tbl[5] = '{8'd5, 8'd6};
        tbl[6] = '{8'd6, 8'd5};
        tbl[7] = '{8'd7, 8'd4};

        rst_i                 = 1'b0;
        en_i                  = 1'b0;
        bus_if.veri_i         = 8'h00;
        bus_if.veri_gecerli_i = 1'b0;
        bus_if.alici_hazir_i  = 1'b1;
        tick();
        tick();
        check("rst_durum", 32'(durum), 0);
        check("rst_veri_al", 32'(bus_if.veri_al_o), 0);
        check("rst_gonder", 32'(bus_if.veri_gonder_o), 0);
        check("rst_bitti", 32'(bus_if.islem_bitti_o), 0);
        check("rst_veri_o", 32'(bus_if.veri_o), 0);
        check("rst_indis", 32'(indis), 0);
        rst_i = 1'b1;
        tick();

        // Valid data while idle must not be taken
        bus_if.veri_gecerli_i = 1'b1;
        bus_if.veri_i         = 8'hAA;
        tick();
        check("idle_veri_al", 32'(bus_if.veri_al_o), 0);
        check("idle_indis", 32'(indis), 0);
        check("idle_durum", 32'(durum), 0);
        bus_if.veri_gecerli_i = 1'b0;

        // Back-to-back frame
        start();
        load(8'd0, 8, 1'b0);
        collect(8'd0, 1'b0);

        // en held high keeps the block parked in BITTI
        for (int i = 0; i < 5; i++) tick();
        check("hold_durum", 32'(durum), 5);
        check("hold_bitti", 32'(bus_if.islem_bitti_o), 1);
        en_i = 1'b0;
        tick();
        check("release_durum", 32'(durum), 0);
        check("release_bitti", 32'(bus_if.islem_bitti_o), 0);

        // Bubbled load and stalled output
        start();
        load(8'd0, 8, 1'b1);
        collect(8'd0, 1'b1);
        en_i = 1'b0;
        tick();

        // Reset in the middle of a load
        start();
        load(8'd10, 5, 1'b0);
        check("pre_rst_indis", 32'(indis), 5);
        rst_i = 1'b0;
        #1;
        check("midrst_durum", 32'(durum), 0);
        check("midrst_veri_al", 32'(bus_if.veri_al_o), 0);
        check("midrst_gonder", 32'(bus_if.veri_gonder_o), 0);
        check("midrst_bitti", 32'(bus_if.islem_bitti_o), 0);
        check("midrst_veri_o", 32'(bus_if.veri_o), 0);
        check("midrst_indis", 32'(indis), 0);
        en_i = 1'b0;
        tick();
        rst_i = 1'b1;
        tick();
        start();
        load(8'd10, 8, 1'b0);
        collect(8'd10, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
`default_nettype wire
